agnus_sprite_dma_sequencer: RTL and testbench
=============================================

# agnus_sprite_dma_sequencer

Upstream feeder of the Denise sprite shifters. For each of the 8 sprites it keeps the DMA pointer and vertical start/stop, and runs a per-sprite state machine. In the fixed sprite DMA slots it fetches control words (POS/CTL) and image words (DATA/DATB) from chip RAM. Each fetched word goes to the matching Denise sprite register through the register address bus.

## Interface
Parameters:
- VBSTOP, 9'd25: first line after vertical blank; all sprites fetch control words on this line.
- SLOT_BASE, 9'h015: colour clock of the first sprite DMA slot.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  28 MHz clock
- reset  in  1  synchronous, active-high
- clk7_en  in  1  7 MHz clock enable; all state updates are qualified by it
- cck_en  in  1  colour-clock boundary qualifier (subset of clk7_en)
- hpos  in  9  colour-clock counter, 0..227
- vpos  in  9  line counter
- dmaen  in  1  sprite DMA enable (DMACON SPREN & DMAEN)
- reg_address_in  in  8  CPU/copper register write address, byte address [8:1]
- data_in  in  16  chip bus data (CPU register writes and DMA reads)
- dma  out  1  sprite DMA owns the current slot
- address_out  out  20  chip RAM word address [20:1]
- reg_address_out  out  8  Denise destination register, byte address [8:1]

## Operation
- Slots: on a cck_en cycle with hpos = SLOT_BASE + 2k, k = 0..15, the sprite is n = k>>1 and the word index is k[0].
- Per-sprite states: IDLE, FETCH_CTL, WAIT_START, ACTIVE.
- Line start is a cck_en cycle with hpos==0. The first matching rule applies:
  - vpos==0 → IDLE.
  - vpos==VBSTOP → FETCH_CTL.
  - In WAIT_START or ACTIVE with vpos==vstop → FETCH_CTL.
  - In WAIT_START with vpos==vstart → ACTIVE.
- Slot behaviour in FETCH_CTL:
  - Word 0 reads POS and targets byte address 0x140+8n; vstart[7:0] ← data_in[15:8].
  - Word 1 reads CTL and targets byte address 0x142+8n; vstop[7:0] ← data_in[15:8], vstart[8] ← data_in[2], vstop[8] ← data_in[1].
  - After word 1 the state moves to WAIT_START.
- Slot behaviour in ACTIVE: word 0 targets DATA (0x144+8n), word 1 targets DATB (0x146+8n).
- Slot behaviour in IDLE and WAIT_START: no request.
- For every granted fetch: address_out = pt[n]; pt[n] ← pt[n]+1 at the end of the slot. The 20-bit pointer wraps.
- dmaen=0: dma=0, and no pointer, state or vstart/vstop changes from slots. Line-start transitions still apply.
- CPU writes:
  - 0x120+4n (SPRxPTH) → pt[n][20:16] ← data_in[4:0].
  - 0x122+4n (SPRxPTL) → pt[n][15:1] ← data_in[15:1].
  - 0x140+8n (SPRxPOS) and 0x142+8n (SPRxCTL) update vstart/vstop with the same bit mapping as the DMA fetch; the state is unchanged.
- A CPU write and a DMA increment of the same pointer in one cycle: the CPU write wins.
- vstart==vstop while in WAIT_START: the stop rule has priority, so the sprite refetches control words and never shows image data.

## Timing
- dma, address_out and reg_address_out are combinational from the registered state and slot decode. They are valid for the whole slot clk7_en cycle.
- data_in is sampled on the clk edge closing the slot cycle, so Denise writes happen on that same edge.
- Idle outputs: dma=0, address_out=0, reg_address_out=8'hFF (byte address 0x1FE, no-op).
- Reset values: all states IDLE, pt=0, vstart=vstop=0; outputs at their idle values from the first cycle after reset.
- Reset mid-fetch: the request is dropped in the next cycle and no pointer increment happens.
- State-transition latency: line-start transitions take effect on the cycle after hpos==0. The first slot of the line therefore sees the new state (SLOT_BASE > 0).

## Structure
- Shared package holds: the state enum, register byte addresses (SPRPT_BASE 0x120, SPRPOS_BASE 0x140, NOOP_REG 0x1FE), and the slot-decode helper constants.
- Natural sub-module: agnus_sprite_dma_channel. It holds one sprite's pt, vstart, vstop and state, and is instanced 8× by the top.
- The top does slot decode, the request mux and CPU-write decode.

## Test plan
- PTH/PTL of sprite 0 = 0x01000; line VBSTOP → slots 0/1 request addresses 0x01000 and 0x01001, reg_address_out = 0xA0 and 0xA1; pt0 = 0x01002 afterwards.
- POS = 0x3000, CTL = 0x3200 → WAIT_START; line 0x30 gives ACTIVE; lines 0x30–0x31 fetch DATA/DATB; line 0x32 fetches new POS/CTL.
- dmaen=0 across a full frame → dma never asserted; pt unchanged.
- CPU write to SPR3PTL in the same cycle as the sprite-3 slot → pt3 equals the written value, with no increment.
- vstart = vstop = 0x40 → no DATA fetch; control words are refetched on line 0x40.
- Reset asserted during slot 5 → dma=0 on the next cycle; all channels IDLE; pt=0.

Source files
------------

// File: rtl/agnus_sprite_dma_sequencer_pkg.sv
// Shared types and register map for the Agnus sprite DMA sequencer.
// Addresses are byte addresses; the register bus carries bits [8:1].
package agnus_sprite_dma_sequencer_pkg;

   typedef enum logic [1:0] {
      SPR_IDLE,
      SPR_FETCH_CTL,
      SPR_WAIT_START,
      SPR_ACTIVE
   } spr_state_e;

   localparam int NUM_SPRITES = 8;
   localparam int NUM_SLOTS   = 16;

   localparam logic [8:0] SPRPT_BASE  = 9'h120;
   localparam logic [8:0] SPRPOS_BASE = 9'h140;
   localparam logic [8:0] NOOP_REG    = 9'h1FE;

   // 16 slots, one every other colour clock
   localparam logic [8:0] SLOT_SPAN = 9'(2 * NUM_SLOTS);

   function automatic logic [7:0] reg_word(input logic [8:0] byte_addr);
      return byte_addr[8:1];
   endfunction

endpackage

// File: rtl/agnus_sprite_dma_channel.sv
// One sprite channel: DMA pointer, vertical start/stop and the per-sprite
// state machine. Slot and CPU-write decode is done by the parent.
module agnus_sprite_dma_channel
   import agnus_sprite_dma_sequencer_pkg::*;
#(
   parameter logic [8:0] VBSTOP = 9'd25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic        line_start_i,
   input  logic [8:0]  vpos_i,
   input  logic        fetch_i,
   input  logic        word_i,
   input  logic [15:0] data_i,
   input  logic        wr_pth_i,
   input  logic        wr_ptl_i,
   input  logic        wr_pos_i,
   input  logic        wr_ctl_i,
   output spr_state_e  state_o,
   output logic [19:0] pt_o
);

   spr_state_e  state_q;
   logic [19:0] pt_q, pt_d;
   logic [8:0]  vstart_q, vstart_d;
   logic [8:0]  vstop_q, vstop_d;
   logic        ctl_fetch;
   logic        pos_load, ctl_load;

   assign ctl_fetch = fetch_i && (state_q == SPR_FETCH_CTL);
   assign pos_load  = wr_pos_i || (ctl_fetch && !word_i);
   assign ctl_load  = wr_ctl_i || (ctl_fetch && word_i);

   always_comb begin
      pt_d     = pt_q;
      vstart_d = vstart_q;
      vstop_d  = vstop_q;
      // A CPU pointer write suppresses the slot's increment entirely
      if (wr_pth_i || wr_ptl_i) begin
         if (wr_pth_i) pt_d[19:15] = data_i[4:0];
         if (wr_ptl_i) pt_d[14:0]  = data_i[15:1];
      end else if (fetch_i) begin
         pt_d = pt_q + 20'd1;
      end
      if (pos_load) vstart_d[7:0] = data_i[15:8];
      if (ctl_load) begin
         vstop_d[7:0] = data_i[15:8];
         vstart_d[8]  = data_i[2];
         vstop_d[8]   = data_i[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= SPR_IDLE;
         pt_q     <= '0;
         vstart_q <= '0;
         vstop_q  <= '0;
      end else if (clk7_en) begin
         pt_q     <= pt_d;
         vstart_q <= vstart_d;
         vstop_q  <= vstop_d;
         if (line_start_i) begin
            // Stop is tested before start so vstart==vstop never shows data
            if (vpos_i == 9'd0)
               state_q <= SPR_IDLE;
            else if (vpos_i == VBSTOP)
               state_q <= SPR_FETCH_CTL;
            else if ((state_q == SPR_WAIT_START || state_q == SPR_ACTIVE) && vpos_i == vstop_q)
               state_q <= SPR_FETCH_CTL;
            else if (state_q == SPR_WAIT_START && vpos_i == vstart_q)
               state_q <= SPR_ACTIVE;
         end else if (ctl_fetch && word_i) begin
            state_q <= SPR_WAIT_START;
         end
      end
   end

   assign state_o = state_q;
   assign pt_o    = pt_q;

endmodule

// File: rtl/agnus_sprite_dma_sequencer.sv
// Sprite DMA sequencer: decodes the fixed sprite slots, muxes the owning
// channel's request onto the chip bus and decodes CPU pointer/POS/CTL writes.
module agnus_sprite_dma_sequencer
   import agnus_sprite_dma_sequencer_pkg::*;
#(
   parameter logic [8:0] VBSTOP    = 9'd25,
   parameter logic [8:0] SLOT_BASE = 9'h015
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk7_en,
   input  logic        cck_en,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic        dmaen,
   input  logic [7:0]  reg_address_in,
   input  logic [15:0] data_in,
   output logic        dma,
   output logic [19:0] address_out,
   output logic [7:0]  reg_address_out
);

   logic [8:0]  slot_off;
   logic        slot_hit;
   logic [2:0]  slot_sprite;
   logic        slot_word;
   logic        line_start;
   spr_state_e  chan_state [NUM_SPRITES];
   logic [19:0] chan_pt    [NUM_SPRITES];
   spr_state_e  cur_state;

   assign slot_off    = hpos - SLOT_BASE;
   assign slot_hit    = cck_en && (hpos >= SLOT_BASE) && (slot_off < SLOT_SPAN) && !slot_off[0];
   assign slot_sprite = slot_off[4:2];
   assign slot_word   = slot_off[1];
   assign line_start  = cck_en && (hpos == 9'd0);

   assign cur_state = chan_state[slot_sprite];
   assign dma = slot_hit && dmaen && (cur_state == SPR_FETCH_CTL || cur_state == SPR_ACTIVE);

   // Denise target: POS/CTL while fetching control, DATA/DATB while active
   always_comb begin
      address_out     = '0;
      reg_address_out = reg_word(NOOP_REG);
      if (dma) begin
         address_out     = chan_pt[slot_sprite];
         reg_address_out = reg_word(SPRPOS_BASE) + {3'b000, slot_sprite, 2'b00}
                         + {6'b000000, (cur_state == SPR_ACTIVE), slot_word};
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_chan
         logic wr_pth, wr_ptl, wr_pos, wr_ctl;
         assign wr_pth = (reg_address_in == reg_word(SPRPT_BASE)  + 8'(2 * gi));
         assign wr_ptl = (reg_address_in == reg_word(SPRPT_BASE)  + 8'(2 * gi + 1));
         assign wr_pos = (reg_address_in == reg_word(SPRPOS_BASE) + 8'(4 * gi));
         assign wr_ctl = (reg_address_in == reg_word(SPRPOS_BASE) + 8'(4 * gi + 1));

         agnus_sprite_dma_channel #(
            .VBSTOP (VBSTOP)
         ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .clk7_en      (clk7_en),
            .line_start_i (line_start),
            .vpos_i       (vpos),
            .fetch_i      (dma && (slot_sprite == 3'(gi))),
            .word_i       (slot_word),
            .data_i       (data_in),
            .wr_pth_i     (wr_pth),
            .wr_ptl_i     (wr_ptl),
            .wr_pos_i     (wr_pos),
            .wr_ctl_i     (wr_ctl),
            .state_o      (chan_state[gi]),
            .pt_o         (chan_pt[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_agnus_sprite_dma_sequencer.sv
// Directed bench for the sprite DMA sequencer: a table of lines with expected
// sprite 0/3 slot behaviour, plus hand-written collision, wrap and reset cases.
module tb_agnus_sprite_dma_sequencer;

   localparam logic [8:0] VBSTOP    = 9'd25;
   localparam logic [8:0] SLOT_BASE = 9'h015;

   logic        clk = 1'b0;
   logic        reset, clk7_en, cck_en, dmaen;
   logic [8:0]  hpos, vpos;
   logic [7:0]  reg_address_in;
   logic [15:0] data_in;
   logic        dma;
   logic [19:0] address_out;
   logic [7:0]  reg_address_out;

   agnus_sprite_dma_sequencer #(
      .VBSTOP    (VBSTOP),
      .SLOT_BASE (SLOT_BASE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clk7_en         (clk7_en),
      .cck_en          (cck_en),
      .hpos            (hpos),
      .vpos            (vpos),
      .dmaen           (dmaen),
      .reg_address_in  (reg_address_in),
      .data_in         (data_in),
      .dma             (dma),
      .address_out     (address_out),
      .reg_address_out (reg_address_out)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n_dma;

   logic        s_dma  [16];
   logic [19:0] s_addr [16];
   logic [7:0]  s_reg  [16];
   logic [15:0] pos_tab [8];
   logic [15:0] ctl_tab [8];

   typedef struct {
      logic [8:0]  vpos;
      logic        en;
      int          cnt;
      logic        d0;
      logic [19:0] a0;
      logic        c0;
      logic        d3;
      logic [19:0] a3;
      logic        c3;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One colour clock: slot cycle, then three cycles with cck_en low
   task automatic cc(input logic [8:0] h);
      hpos    = h;
      cck_en  = 1'b1;
      clk7_en = 1'b1;
      @(negedge clk);
      if (dma) n_dma++;
      s_dma[0] = s_dma[0];
      @(posedge clk); #1;
      cck_en = 1'b0; clk7_en = 1'b0; reg_address_in = 8'hFF;
      @(posedge clk); #1;
      clk7_en = 1'b1;
      @(negedge clk);
      if (dma) n_dma++;
      @(posedge clk); #1;
      clk7_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
      reg_address_in = a;
      data_in        = d;
      cc(9'd1);
   endtask

   task automatic slot(input int k);
      hpos    = SLOT_BASE + 9'(2 * k);
      cck_en  = 1'b1;
      clk7_en = 1'b1;
      @(negedge clk);
      s_dma[k]  = dma;
      s_addr[k] = address_out;
      s_reg[k]  = reg_address_out;
      if (dma) n_dma++;
      @(posedge clk); #1;
      cck_en = 1'b0; clk7_en = 1'b0; reg_address_in = 8'hFF;
      @(posedge clk); #1;
      clk7_en = 1'b1;
      @(negedge clk);
      if (dma) n_dma++;
      @(posedge clk); #1;
      clk7_en = 1'b0;
      @(posedge clk); #1;
      cc(SLOT_BASE + 9'(2 * k + 1));
   endtask

   task automatic run_line(input logic [8:0] v, input logic en, input int wr_slot,
                           input logic [7:0] wr_a, input logic [15:0] wr_d);
      vpos    = v;
      dmaen   = en;
      data_in = 16'h0000;
      n_dma   = 0;
      cc(9'd0);
      for (int k = 0; k < 16; k++) begin
         data_in = k[0] ? ctl_tab[k >> 1] : pos_tab[k >> 1];
         if (k == wr_slot) begin
            reg_address_in = wr_a;
            data_in        = wr_d;
         end
         slot(k);
      end
   endtask

   task automatic check_sprite(input int n, input logic ed, input logic [19:0] ea,
                               input logic ec, input string tag);
      int k;
      logic [7:0]  er;
      logic [19:0] eaw;
      for (int w = 0; w < 2; w++) begin
         k   = 2 * n + w;
         er  = ed ? (8'hA0 + 8'(4 * n) + (ec ? 8'd0 : 8'd2) + 8'(w)) : 8'hFF;
         eaw = ed ? (ea + 20'(w)) : 20'h0;
         check($sformatf("%s sp%0d w%0d dma", tag, n, w), 32'(s_dma[k]), 32'(ed));
         check($sformatf("%s sp%0d w%0d addr", tag, n, w), 32'(s_addr[k]), 32'(eaw));
         check($sformatf("%s sp%0d w%0d reg", tag, n, w), 32'(s_reg[k]), 32'(er));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clk7_en = 1'b0; cck_en = 1'b0; dmaen = 1'b1;
      hpos = 9'd0; vpos = 9'd100; reg_address_in = 8'hFF; data_in = 16'h0;
      n_dma = 0;
      for (int i = 0; i < 16; i++) begin
         s_dma[i] = 1'b0; s_addr[i] = '0; s_reg[i] = 8'h00;
      end
      for (int i = 0; i < 8; i++) begin
         pos_tab[i] = 16'h0000; ctl_tab[i] = 16'h0000;
      end
      pos_tab[0] = 16'h3000; ctl_tab[0] = 16'h3200;
      pos_tab[3] = 16'h4000; ctl_tab[3] = 16'h4000;

      //            vpos    en   cnt d0  a0         c0  d3  a3         c3
      tbl[0]  = '{VBSTOP, 1'b1, 16, 1'b1, 20'h01000, 1'b1, 1'b1, 20'h18200, 1'b1};
      tbl[1]  = '{9'h02F, 1'b1, 0,  1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[2]  = '{9'h030, 1'b1, 2,  1'b1, 20'h01002, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[3]  = '{9'h031, 1'b1, 2,  1'b1, 20'h01004, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[4]  = '{9'h032, 1'b1, 2,  1'b1, 20'h01006, 1'b1, 1'b0, 20'h00000, 1'b0};
      tbl[5]  = '{9'h040, 1'b1, 2,  1'b0, 20'h00000, 1'b0, 1'b1, 20'h18202, 1'b1};
      tbl[6]  = '{9'h041, 1'b1, 0,  1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[7]  = '{9'h000, 1'b0, 0,  1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[8]  = '{VBSTOP, 1'b0, 0,  1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[9]  = '{9'h030, 1'b0, 0,  1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 1'b0};
      tbl[10] = '{9'h031, 1'b1, 16, 1'b1, 20'h01008, 1'b1, 1'b1, 20'h18204, 1'b1};
      tbl[11] = '{9'h032, 1'b1, 2,  1'b1, 20'h0100A, 1'b1, 1'b0, 20'h00000, 1'b0};

      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      // Reset state: channels idle, so even a live slot stays quiet
      hpos = SLOT_BASE; cck_en = 1'b1; clk7_en = 1'b1;
      @(negedge clk);
      check("reset dma", 32'(dma), 32'h0);
      check("reset addr", 32'(address_out), 32'h0);
      check("reset reg", 32'(reg_address_out), 32'hFF);
      @(posedge clk); #1;
      cck_en = 1'b0; clk7_en = 1'b0;
      $display("[TB] reset state checked");

      // Pointers: sprite 0 = 0x01000, sprite 3 = 0x18200 (word addresses)
      cpu_write(8'h90, 16'h0000);
      cpu_write(8'h91, 16'h2000);
      cpu_write(8'h96, 16'h0003);
      cpu_write(8'h97, 16'h0400);

      for (int i = 0; i < 12; i++) begin
         run_line(tbl[i].vpos, tbl[i].en, -1, 8'hFF, 16'h0);
         check($sformatf("v%0d line%0h dma count", i, tbl[i].vpos), 32'(n_dma), 32'(tbl[i].cnt));
         check_sprite(0, tbl[i].d0, tbl[i].a0, tbl[i].c0, $sformatf("v%0d", i));
         check_sprite(3, tbl[i].d3, tbl[i].a3, tbl[i].c3, $sformatf("v%0d", i));
         $display("[TB] vec %0d line 0x%0h dmaen=%0d dma_slots=%0d", i, tbl[i].vpos, tbl[i].en, n_dma);
      end

      // SPR3PTL write collides with sprite 3's first control slot
      run_line(9'h040, 1'b1, 6, 8'h97, 16'h4000);
      check("ptl collide count", 32'(n_dma), 32'd2);
      check("ptl collide slot6 addr", 32'(s_addr[6]), 32'h18206);
      check("ptl collide slot6 reg", 32'(s_reg[6]), 32'hAC);
      check("ptl collide slot7 addr", 32'(s_addr[7]), 32'h1A000);
      check("ptl collide slot7 reg", 32'(s_reg[7]), 32'hAD);
      $display("[TB] cpu PTL write during sprite 3 slot, slot7 addr 0x%0h", s_addr[7]);

      // CPU POS/CTL with bit 8 set: vstart=0x110, vstop=0x120, state unchanged
      cpu_write(8'hA0, 16'h1000);
      cpu_write(8'hA1, 16'h2006);
      run_line(9'h010, 1'b1, -1, 8'hFF, 16'h0);
      check("pos8 line 0x010 count", 32'(n_dma), 32'd0);
      run_line(9'h110, 1'b1, -1, 8'hFF, 16'h0);
      check("pos8 line 0x110 count", 32'(n_dma), 32'd2);
      check_sprite(0, 1'b1, 20'h0100C, 1'b0, "pos8 start");
      run_line(9'h120, 1'b1, -1, 8'hFF, 16'h0);
      check_sprite(0, 1'b1, 20'h0100E, 1'b1, "pos8 stop");
      $display("[TB] cpu POS/CTL with vertical bit 8 checked");

      // Pointer wrap at the top of chip RAM
      cpu_write(8'h90, 16'h001F);
      cpu_write(8'h91, 16'hFFFE);
      run_line(VBSTOP, 1'b1, -1, 8'hFF, 16'h0);
      check("wrap count", 32'(n_dma), 32'd16);
      check("wrap slot0 addr", 32'(s_addr[0]), 32'hFFFFF);
      check("wrap slot1 addr", 32'(s_addr[1]), 32'h00000);
      $display("[TB] pointer wrap 0x%0h -> 0x%0h", s_addr[0], s_addr[1]);

      // Reset asserted during slot 5 of a control-fetch line
      vpos = VBSTOP; dmaen = 1'b1; n_dma = 0;
      cc(9'd0);
      for (int k = 0; k < 5; k++) begin
         data_in = k[0] ? ctl_tab[k >> 1] : pos_tab[k >> 1];
         slot(k);
      end
      hpos = SLOT_BASE + 9'd10; cck_en = 1'b1; clk7_en = 1'b1; reset = 1'b1;
      @(negedge clk);
      check("rst slot5 dma before", 32'(dma), 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst slot5 dma after", 32'(dma), 32'h0);
      check("rst slot5 addr after", 32'(address_out), 32'h0);
      check("rst slot5 reg after", 32'(reg_address_out), 32'hFF);
      @(posedge clk); #1;
      cck_en = 1'b0; clk7_en = 1'b0;
      run_line(9'h030, 1'b1, -1, 8'hFF, 16'h0);
      check("post reset idle count", 32'(n_dma), 32'd0);
      run_line(VBSTOP, 1'b1, -1, 8'hFF, 16'h0);
      check("post reset vbstop count", 32'(n_dma), 32'd16);
      check_sprite(0, 1'b1, 20'h00000, 1'b1, "post reset");
      check_sprite(3, 1'b1, 20'h00000, 1'b1, "post reset");
      $display("[TB] reset during slot 5 checked");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
